// File: rtl/tic_tac_toe_pkg.sv
// Shared encodings for the tic-tac-toe turn controller.
package tic_tac_toe_pkg;

    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_PLAYER = 2'b01;
    localparam logic [1:0] WHO_COMP   = 2'b10;

    localparam int NUM_CELLS = 9;

    typedef enum logic [2:0] {
        P_TURN,
        P_WRITE,
        P_CHECK,
        C_TURN,
        C_WRITE,
        C_CHECK,
        OVER
    } state_t;

endpackage

// File: rtl/tic_tac_toe_move_check.sv
// Combinational move legality: position on the board and the cell still free.
module tic_tac_toe_move_check #(
    parameter int NUM_CELLS = 9,
    parameter int POS_W     = 4
) (
    input  logic [POS_W-1:0]     pos,
    input  logic [NUM_CELLS-1:0] cell_occupied,
    output logic                 legal
);

    // Occupancy widened to the full position range so any pos indexes safely.
    logic [2**POS_W-1:0] occ_ext;

    // Out-of-range positions are illegal regardless of the padded occupancy bits.
    always_comb begin
        occ_ext                  = '0;
        occ_ext[NUM_CELLS-1:0]   = cell_occupied;
        legal = (int'(pos) < NUM_CELLS) && !occ_ext[pos];
    end

endmodule

// File: rtl/tic_tac_toe_turn_ctrl.sv
// Turn sequencer for the tic-tac-toe board: grants the in-turn side, rejects
// illegal cells, issues one write strobe per accepted move, samples the
// win/draw detector and bounds the computer's reply time.
module tic_tac_toe_turn_ctrl #(
    parameter int NUM_CELLS  = tic_tac_toe_pkg::NUM_CELLS,
    parameter int POS_W      = 4,
    parameter int PC_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 play,
    input  logic [POS_W-1:0]     player_position,
    input  logic                 pc,
    input  logic [POS_W-1:0]     computer_position,
    input  logic [NUM_CELLS-1:0] cell_occupied,
    input  logic                 game_done,
    output logic                 wr_en,
    output logic [POS_W-1:0]     wr_pos,
    output logic [1:0]           wr_who,
    output logic                 play_ack,
    output logic                 pc_ack,
    output logic                 illegal,
    output logic                 pc_timeout,
    output logic [1:0]           turn,
    output logic [3:0]           move_count,
    output logic                 game_over
);

    import tic_tac_toe_pkg::*;

    localparam logic [3:0] MAX_MOVES = 4'(NUM_CELLS);
    localparam logic [7:0] TMO_LAST  = 8'(PC_TIMEOUT - 1);

    state_t           state;
    logic [7:0]       timer;
    logic             p_armed;    // player may be accepted (dropped play since last ack)
    logic             c_armed;    // computer may be accepted (dropped pc since last ack)
    logic [POS_W-1:0] chk_pos;
    logic             legal;

    // One legality checker, fed by whichever side holds the turn.
    assign chk_pos = (turn == WHO_COMP) ? computer_position : player_position;

    tic_tac_toe_move_check #(
        .NUM_CELLS (NUM_CELLS),
        .POS_W     (POS_W)
    ) u_move_check (
        .pos           (chk_pos),
        .cell_occupied (cell_occupied),
        .legal         (legal)
    );

    // Turn FSM; strobes and write fields are registered at the accept edge so
    // they appear during the *_WRITE state, and default back to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= P_TURN;
            turn       <= WHO_PLAYER;
            wr_en      <= 1'b0;
            wr_pos     <= '0;
            wr_who     <= WHO_NONE;
            play_ack   <= 1'b0;
            pc_ack     <= 1'b0;
            illegal    <= 1'b0;
            pc_timeout <= 1'b0;
            move_count <= 4'd0;
            game_over  <= 1'b0;
            timer      <= 8'd0;
            p_armed    <= 1'b1;
            c_armed    <= 1'b1;
        end else begin
            wr_en      <= 1'b0;
            wr_pos     <= '0;
            wr_who     <= WHO_NONE;
            play_ack   <= 1'b0;
            pc_ack     <= 1'b0;
            illegal    <= 1'b0;
            pc_timeout <= 1'b0;
            if (!play) p_armed <= 1'b1;
            if (!pc)   c_armed <= 1'b1;

            case (state)
                P_TURN: begin
                    if (play && p_armed) begin
                        if (legal) begin
                            state    <= P_WRITE;
                            wr_en    <= 1'b1;
                            wr_pos   <= player_position;
                            wr_who   <= WHO_PLAYER;
                            play_ack <= 1'b1;
                            p_armed  <= 1'b0;
                            if (move_count != MAX_MOVES) move_count <= move_count + 4'd1;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                P_WRITE: state <= P_CHECK;
                P_CHECK: begin
                    if (game_done || move_count == MAX_MOVES) begin
                        state     <= OVER;
                        turn      <= WHO_NONE;
                        game_over <= 1'b1;
                    end else begin
                        state <= C_TURN;
                        turn  <= WHO_COMP;
                        timer <= 8'd0;
                    end
                end
                C_TURN: begin
                    if (pc && c_armed && legal) begin
                        state   <= C_WRITE;
                        wr_en   <= 1'b1;
                        wr_pos  <= computer_position;
                        wr_who  <= WHO_COMP;
                        pc_ack  <= 1'b1;
                        c_armed <= 1'b0;
                        if (move_count != MAX_MOVES) move_count <= move_count + 4'd1;
                    end else begin
                        // Illegal requests flag but keep the clock running.
                        if (pc && c_armed) illegal <= 1'b1;
                        if (timer == TMO_LAST) begin
                            pc_timeout <= 1'b1;
                            state      <= P_TURN;
                            turn       <= WHO_PLAYER;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                C_WRITE: state <= C_CHECK;
                C_CHECK: begin
                    if (game_done || move_count == MAX_MOVES) begin
                        state     <= OVER;
                        turn      <= WHO_NONE;
                        game_over <= 1'b1;
                    end else begin
                        state <= P_TURN;
                        turn  <= WHO_PLAYER;
                    end
                end
                OVER: begin
                    turn      <= WHO_NONE;
                    game_over <= 1'b1;
                end
                default: state <= P_TURN;
            endcase
        end
    end

endmodule

// File: tb/tb_tic_tac_toe_turn_ctrl.sv
// Bench for tic_tac_toe_turn_ctrl: vector table, hand sequences for timeout,
// game end and reset mid-write, then randomized play against a rule model.
module tb_tic_tac_toe_turn_ctrl;

    localparam int PC_TIMEOUT = 15;

    logic       clock = 1'b0;
    logic       reset, play, pc, game_done;
    logic [3:0] player_position, computer_position;
    logic [8:0] cell_occupied;
    logic       wr_en, play_ack, pc_ack, illegal, pc_timeout, game_over;
    logic [3:0] wr_pos, move_count;
    logic [1:0] wr_who, turn;

    tic_tac_toe_turn_ctrl #(.NUM_CELLS(9), .POS_W(4), .PC_TIMEOUT(PC_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .play(play), .player_position(player_position),
        .pc(pc), .computer_position(computer_position), .cell_occupied(cell_occupied),
        .game_done(game_done), .wr_en(wr_en), .wr_pos(wr_pos), .wr_who(wr_who),
        .play_ack(play_ack), .pc_ack(pc_ack), .illegal(illegal), .pc_timeout(pc_timeout),
        .turn(turn), .move_count(move_count), .game_over(game_over)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the coming cycle.
    logic       e_wr_en, e_pa, e_ca, e_ill, e_tmo, e_go;
    logic [3:0] e_wr_pos, e_mc;
    logic [1:0] e_wr_who, e_turn;

    task automatic cmp_all(input string tag);
        chk({tag, ".wr_en"},      wr_en,      e_wr_en);
        chk({tag, ".wr_pos"},     wr_pos,     e_wr_pos);
        chk({tag, ".wr_who"},     wr_who,     e_wr_who);
        chk({tag, ".play_ack"},   play_ack,   e_pa);
        chk({tag, ".pc_ack"},     pc_ack,     e_ca);
        chk({tag, ".illegal"},    illegal,    e_ill);
        chk({tag, ".pc_timeout"}, pc_timeout, e_tmo);
        chk({tag, ".turn"},       turn,       e_turn);
        chk({tag, ".move_count"}, move_count, e_mc);
        chk({tag, ".game_over"},  game_over,  e_go);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    typedef struct {
        logic rst; logic ply; logic [3:0] ppos; logic cpc; logic [3:0] cpos;
        logic [8:0] occ; logic gd;
        logic wr; logic [3:0] wpos; logic [1:0] who; logic pa; logic ca; logic ill; logic tmo;
        logic [1:0] trn; logic [3:0] mc; logic go;
    } vec_t;

    vec_t tbl[13];

    // ---------------- reference model (game rules, not states) ----------------
    int  board[9];          // 0 empty, 1 player, 2 computer
    bit  m_over;
    int  m_side;            // 1 player to move, 2 computer to move
    int  m_busy;            // cycles of write/check left after an accepted move
    int  m_wait;            // cycles the computer has spent on its turn
    int  m_moves;
    bit  m_fp, m_fc;        // side has released its request since last accept

    function automatic bit line3(int a, int b, int c);
        return board[a] != 0 && board[a] == board[b] && board[b] == board[c];
    endfunction

    function automatic bit win();
        return line3(0,1,2) || line3(3,4,5) || line3(6,7,8) || line3(0,3,6) ||
               line3(1,4,7) || line3(2,5,8) || line3(0,4,8) || line3(2,4,6);
    endfunction

    function automatic logic [8:0] occ_of_board();
        logic [8:0] o;
        for (int i = 0; i < 9; i++) o[i] = (board[i] != 0);
        return o;
    endfunction

    function automatic logic [3:0] pick_pos();
        if ($urandom_range(0, 9) < 7) begin
            for (int t = 0; t < 20; t++) begin
                int c;
                c = $urandom_range(0, 8);
                if (board[c] == 0) return 4'(c);
            end
        end
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic model_step();
        bit req, fresh, ok;
        int p;
        e_wr_en = 0; e_wr_pos = 0; e_wr_who = 0; e_pa = 0; e_ca = 0; e_ill = 0; e_tmo = 0;
        if (reset) begin
            m_over = 0; m_side = 1; m_busy = 0; m_wait = 0; m_moves = 0; m_fp = 1; m_fc = 1;
            for (int i = 0; i < 9; i++) board[i] = 0;
        end else begin
            if (!m_over) begin
                if (m_busy == 2) begin
                    m_busy = 1;
                end else if (m_busy == 1) begin
                    m_busy = 0;
                    if (game_done || m_moves == 9) m_over = 1;
                    else begin
                        m_side = 3 - m_side;
                        m_wait = 0;
                    end
                end else begin
                    req   = (m_side == 1) ? play : pc;
                    fresh = (m_side == 1) ? m_fp : m_fc;
                    p     = (m_side == 1) ? int'(player_position) : int'(computer_position);
                    ok    = 0;
                    if (req && fresh) begin
                        if (p < 9 && board[p] == 0) begin
                            ok = 1;
                            e_wr_en = 1; e_wr_pos = 4'(p); e_wr_who = 2'(m_side);
                            if (m_side == 1) begin e_pa = 1; m_fp = 0; end
                            else             begin e_ca = 1; m_fc = 0; end
                            if (m_moves < 9) m_moves++;
                            board[p] = m_side;
                            m_busy = 2;
                        end else begin
                            e_ill = 1;
                        end
                    end
                    if (m_side == 2 && !ok) begin
                        m_wait++;
                        if (m_wait == PC_TIMEOUT) begin
                            e_tmo  = 1;
                            m_side = 1;
                        end
                    end
                end
            end
            if (!play) m_fp = 1;
            if (!pc)   m_fc = 1;
        end
        e_turn = m_over ? 2'b00 : 2'(m_side);
        e_go   = m_over;
        e_mc   = 4'(m_moves);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int pc_prob;

        reset = 1; play = 0; pc = 0; game_done = 0;
        player_position = 0; computer_position = 0; cell_occupied = 0;

        // Reset held for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst.turn", turn, 2'b01);
            chk("rst.move_count", move_count, 0);
            chk("rst.wr_en", wr_en, 0);
            chk("rst.game_over", game_over, 0);
        end

        //          rst ply ppos cpc cpos occ     gd  wr wpos who   pa ca il tm trn    mc go
        tbl[0]  = '{1, 0, 0,  0, 0, 9'h000, 0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0};
        tbl[1]  = '{0, 1, 9,  0, 0, 9'h000, 0,  0, 0, 2'b00, 0, 0, 1, 0, 2'b01, 0, 0};
        tbl[2]  = '{0, 1, 15, 0, 0, 9'h000, 0,  0, 0, 2'b00, 0, 0, 1, 0, 2'b01, 0, 0};
        tbl[3]  = '{0, 0, 0,  1, 3, 9'h000, 0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0};
        tbl[4]  = '{0, 1, 0,  0, 0, 9'h000, 0,  1, 0, 2'b01, 1, 0, 0, 0, 2'b01, 1, 0};
        tbl[5]  = '{0, 1, 0,  0, 0, 9'h001, 0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 1, 0};
        tbl[6]  = '{0, 0, 0,  0, 0, 9'h001, 0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0};
        tbl[7]  = '{0, 0, 0,  1, 0, 9'h001, 0,  0, 0, 2'b00, 0, 0, 1, 0, 2'b10, 1, 0};
        tbl[8]  = '{0, 0, 0,  1, 4, 9'h001, 0,  1, 4, 2'b10, 0, 1, 0, 0, 2'b10, 2, 0};
        tbl[9]  = '{0, 0, 0,  1, 4, 9'h011, 0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2, 0};
        tbl[10] = '{0, 0, 0,  0, 0, 9'h011, 0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2, 0};
        tbl[11] = '{0, 1, 4,  0, 0, 9'h011, 0,  0, 0, 2'b00, 0, 0, 1, 0, 2'b01, 2, 0};
        tbl[12] = '{0, 0, 0,  0, 0, 9'h011, 0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2, 0};

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; play = tbl[i].ply; player_position = tbl[i].ppos;
            pc = tbl[i].cpc; computer_position = tbl[i].cpos;
            cell_occupied = tbl[i].occ; game_done = tbl[i].gd;
            e_wr_en = tbl[i].wr; e_wr_pos = tbl[i].wpos; e_wr_who = tbl[i].who;
            e_pa = tbl[i].pa; e_ca = tbl[i].ca; e_ill = tbl[i].ill; e_tmo = tbl[i].tmo;
            e_turn = tbl[i].trn; e_mc = tbl[i].mc; e_go = tbl[i].go;
            tick();
            cmp_all($sformatf("vec%0d", i));
        end

        // Computer timeout: player moves cell 1, computer stays silent.
        play = 1; player_position = 1; tick();
        chk("tmo.wr_en", wr_en, 1); chk("tmo.wr_pos", wr_pos, 1); chk("tmo.mc", move_count, 3);
        play = 0; cell_occupied = 9'h013; tick();
        tick();
        chk("tmo.turn_comp", turn, 2'b10);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 15)       chk("tmo.early", pc_timeout, 0);
            else if (k == 15) begin
                chk("tmo.pulse", pc_timeout, 1);
                chk("tmo.turn", turn, 2'b01);
                chk("tmo.mc_kept", move_count, 3);
            end else          chk("tmo.after", pc_timeout, 0);
        end

        // Game end after move 5 taken by the player.
        play = 1; player_position = 2; tick();
        chk("go.mc4", move_count, 4);
        play = 0; cell_occupied = 9'h017; tick();
        tick();
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = pc_timeout;
        end
        chk("go.timeout_seen", seen, 1);
        play = 1; player_position = 3; tick();
        chk("go.wr_en", wr_en, 1); chk("go.mc5", move_count, 5);
        play = 0; cell_occupied = 9'h01F; tick();
        game_done = 1; tick();
        game_done = 0;
        chk("go.game_over", game_over, 1); chk("go.turn", turn, 2'b00); chk("go.mc", move_count, 5);
        play = 1; player_position = 6; pc = 1; computer_position = 7;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("go.no_wr", wr_en, 0);
            chk("go.no_ack", {play_ack, pc_ack, illegal}, 0);
            chk("go.hold", game_over, 1);
        end

        // Reset arriving while the computer's write strobe is up.
        reset = 1; play = 0; pc = 0; cell_occupied = 0; tick();
        reset = 0; play = 1; player_position = 0; tick();
        play = 0; cell_occupied = 9'h001; tick();
        tick();
        chk("rw.turn_comp", turn, 2'b10);
        pc = 1; computer_position = 1; tick();
        chk("rw.wr_en", wr_en, 1); chk("rw.wr_who", wr_who, 2'b10);
        reset = 1; pc = 0; tick();
        chk("rw.wr_en_off", wr_en, 0); chk("rw.turn", turn, 2'b01);
        chk("rw.mc", move_count, 0);   chk("rw.go", game_over, 0);
        chk("rw.wr_who", wr_who, 2'b00);

        // Randomized play against the rule model.
        pc_prob = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = (cyc == 0) || (m_over && $urandom_range(0, 5) == 0) || ($urandom_range(0, 299) == 0);
            if (reset) pc_prob = $urandom_range(20, 80);
            play = ($urandom_range(0, 99) < 55);
            pc   = ($urandom_range(0, 99) < pc_prob);
            player_position   = pick_pos();
            computer_position = pick_pos();
            cell_occupied     = occ_of_board();
            game_done = (cyc > 0 && m_busy == 1) ? win() : ($urandom_range(0, 9) == 0);
            model_step();
            tick();
            cmp_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
